// File: rtl/chip_invaders_pkg.sv
// Shared types and widths for the chip_invaders game logic.
// Holds the round phase encoding and the top-level menu/game/end encoding.
package chip_invaders_pkg;

    localparam int SCORE_W  = 16;
    localparam int LEVEL_W  = 4;
    localparam int LIVES_W  = 2;
    localparam int DIV_W    = 5;
    localparam int REMAIN_W = 6;
    localparam int PAUSE_W  = 8;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        GAME = 2'd1,
        END  = 2'd2
    } game_state_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        PLAY  = 3'd2,
        HIT   = 3'd3,
        OVER  = 3'd4
    } round_phase_t;

    // Level 0 (out of round) reads as level 1 so the subtraction never wraps.
    function automatic logic [DIV_W-1:0] calc_step_div(input logic [LEVEL_W-1:0] level,
                                                       input int base_div,
                                                       input int min_div);
        int steps;
        steps = (level == '0) ? 0 : 2 * (int'(level) - 1);
        if (base_div > min_div + steps) return DIV_W'(base_div - steps);
        return DIV_W'(min_div);
    endfunction

endpackage

// File: rtl/game_round_controller_frame_countdown.sv
// Frame-based pause timer shared by the HIT and BREAK phases.
// Loads N (0 treated as 1), counts frame ticks down, pulses done on the tick that ends the pause.
module frame_countdown
    import chip_invaders_pkg::*;
#(
    parameter int W = PAUSE_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_frame_tick,
    output logic         o_done
);

    logic [W-1:0] r_cnt;
    logic         w_at_tc;

    assign w_at_tc = (r_cnt == W'(1));
    assign o_done  = i_en && i_frame_tick && w_at_tc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_load_val == '0) ? W'(1) : i_load_val;
        end else if (i_en && i_frame_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Sequences one round of play while the top level is in GAME: lives, waves, score, pauses.
//   state | meaning
//   IDLE  | waiting for game_active to rise, enables off
//   BREAK | start / inter-wave banner, counting BREAK_FRAMES ticks
//   PLAY  | player and invaders enabled, events resolved
//   HIT   | frozen after a player hit, counting HIT_FRAMES ticks
//   OVER  | round lost, game_over held until game_active falls
module game_round_controller
    import chip_invaders_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int INVADER_COUNT = 32,
    parameter int HIT_FRAMES    = 60,
    parameter int BREAK_FRAMES  = 90,
    parameter int MAX_LEVEL     = 15,
    parameter int POINTS        = 10,
    parameter int BASE_DIV      = 16,
    parameter int MIN_DIV       = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_tick,
    input  logic               i_game_active,
    input  logic               i_player_hit,
    input  logic               i_invader_killed,
    input  logic               i_invaders_landed,
    output logic [2:0]         o_phase,
    output logic               o_player_en,
    output logic               o_invader_en,
    output logic [DIV_W-1:0]   o_step_div,
    output logic [LIVES_W-1:0] o_lives,
    output logic [LEVEL_W-1:0] o_level,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_game_over
);

    round_phase_t          r_phase;
    logic [LIVES_W-1:0]    r_lives;
    logic [LEVEL_W-1:0]    r_level;
    logic [SCORE_W-1:0]    r_score;
    logic [REMAIN_W-1:0]   r_remaining;
    logic                  r_game_active_d;
    logic                  r_player_en;
    logic                  r_invader_en;
    logic                  r_game_over;

    logic                  w_rise;
    logic                  w_in_play;
    logic                  w_start;
    logic                  w_landed;
    logic                  w_hit;
    logic                  w_hit_last;
    logic                  w_kill;
    logic                  w_clear;
    logic                  w_pause_en;
    logic                  w_pause_done;
    logic                  w_load;
    logic [PAUSE_W-1:0]    w_load_val;
    logic [LIVES_W-1:0]    w_lives_dec;
    logic [REMAIN_W-1:0]   w_remaining_next;
    logic [SCORE_W:0]      w_score_sum;
    logic [SCORE_W-1:0]    w_score_next;

    assign w_rise      = i_game_active && !r_game_active_d;
    assign w_in_play   = i_game_active && (r_phase == PLAY);
    assign w_start     = i_game_active && (r_phase == IDLE) && w_rise;
    assign w_landed    = w_in_play && i_invaders_landed;
    assign w_hit       = w_in_play && !i_invaders_landed && i_player_hit;
    assign w_lives_dec = (r_lives == '0) ? '0 : r_lives - LIVES_W'(1);
    assign w_hit_last  = w_hit && (w_lives_dec == '0);
    assign w_kill      = w_in_play && i_invader_killed;

    assign w_remaining_next = (w_kill && (r_remaining != '0)) ? r_remaining - REMAIN_W'(1)
                                                              : r_remaining;
    // Also fires on the first PLAY cycle after a hit swallowed the last kill.
    assign w_clear = w_in_play && !i_invaders_landed && !i_player_hit && (w_remaining_next == '0);

    assign w_score_sum  = {1'b0, r_score} + (SCORE_W+1)'(POINTS);
    assign w_score_next = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

    assign w_pause_en = (r_phase == BREAK) || (r_phase == HIT);
    assign w_load     = w_start || w_clear || (w_hit && !w_hit_last);
    assign w_load_val = w_hit ? PAUSE_W'(HIT_FRAMES) : PAUSE_W'(BREAK_FRAMES);

    frame_countdown #(
        .W (PAUSE_W)
    ) u_pause (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_load),
        .i_load_val   (w_load_val),
        .i_en         (w_pause_en),
        .i_frame_tick (i_frame_tick),
        .o_done       (w_pause_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase         <= IDLE;
            r_lives         <= '0;
            r_level         <= '0;
            r_score         <= '0;
            r_remaining     <= '0;
            r_player_en     <= 1'b0;
            r_invader_en    <= 1'b0;
            r_game_over     <= 1'b0;
            // A game_active that is already high must toggle before a round starts.
            r_game_active_d <= 1'b1;
        end else begin
            r_game_active_d <= i_game_active;
            if (!i_game_active) begin
                r_phase      <= IDLE;
                r_player_en  <= 1'b0;
                r_invader_en <= 1'b0;
                r_game_over  <= 1'b0;
            end else begin
                case (r_phase)
                    IDLE: begin
                        if (w_rise) begin
                            r_lives     <= LIVES_W'(LIVES_INIT);
                            r_level     <= LEVEL_W'(1);
                            r_score     <= '0;
                            r_remaining <= REMAIN_W'(INVADER_COUNT);
                            r_phase     <= BREAK;
                        end
                    end
                    BREAK, HIT: begin
                        if (w_pause_done) begin
                            r_phase      <= PLAY;
                            r_player_en  <= 1'b1;
                            r_invader_en <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (i_invader_killed) r_score <= w_score_next;
                        r_remaining <= w_remaining_next;
                        if (w_landed) begin
                            r_lives      <= '0;
                            r_phase      <= OVER;
                            r_game_over  <= 1'b1;
                            r_player_en  <= 1'b0;
                            r_invader_en <= 1'b0;
                        end else if (w_hit) begin
                            r_lives      <= w_lives_dec;
                            r_player_en  <= 1'b0;
                            r_invader_en <= 1'b0;
                            if (w_hit_last) begin
                                r_phase     <= OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_phase <= HIT;
                            end
                        end else if (w_clear) begin
                            if (r_level < LEVEL_W'(MAX_LEVEL)) r_level <= r_level + LEVEL_W'(1);
                            r_remaining  <= REMAIN_W'(INVADER_COUNT);
                            r_phase      <= BREAK;
                            r_player_en  <= 1'b0;
                            r_invader_en <= 1'b0;
                        end
                    end
                    OVER: begin
                        r_game_over <= 1'b1;
                    end
                    default: begin
                        r_phase <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_phase      = r_phase;
    assign o_player_en  = r_player_en;
    assign o_invader_en = r_invader_en;
    assign o_lives      = r_lives;
    assign o_level      = r_level;
    assign o_score      = r_score;
    assign o_game_over  = r_game_over;
    assign o_step_div   = calc_step_div(r_level, BASE_DIV, MIN_DIV);

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed round scenarios, a rule-level model checked
// every cycle, and literal checkpoints at the interesting moments of each scenario.
module tb_game_round_controller;

    localparam int LIVES_INIT    = 3;
    localparam int INVADER_COUNT = 32;
    localparam int HIT_FRAMES    = 60;
    localparam int BREAK_FRAMES  = 90;
    localparam int MAX_LEVEL     = 15;
    localparam int POINTS        = 10;
    localparam int BASE_DIV      = 16;
    localparam int MIN_DIV       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        game_active;
    logic        player_hit;
    logic        invader_killed;
    logic        invaders_landed;
    logic [2:0]  phase;
    logic        player_en;
    logic        invader_en;
    logic [4:0]  step_div;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [15:0] score;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    game_round_controller #(
        .LIVES_INIT    (LIVES_INIT),
        .INVADER_COUNT (INVADER_COUNT),
        .HIT_FRAMES    (HIT_FRAMES),
        .BREAK_FRAMES  (BREAK_FRAMES),
        .MAX_LEVEL     (MAX_LEVEL),
        .POINTS        (POINTS),
        .BASE_DIV      (BASE_DIV),
        .MIN_DIV       (MIN_DIV)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_frame_tick      (frame_tick),
        .i_game_active     (game_active),
        .i_player_hit      (player_hit),
        .i_invader_killed  (invader_killed),
        .i_invaders_landed (invaders_landed),
        .o_phase           (phase),
        .o_player_en       (player_en),
        .o_invader_en      (invader_en),
        .o_step_div        (step_div),
        .o_lives           (lives),
        .o_level           (level),
        .o_score           (score),
        .o_game_over       (game_over)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Rule-level model: phase 0..4 = IDLE, BREAK, PLAY, HIT, OVER.
    int m_phase, m_lives, m_level, m_score, m_rem, m_pause;
    bit m_prev;
    bit m_valid = 1'b0;

    function automatic int exp_step_div(input int lvl);
        int l, d;
        l = (lvl < 1) ? 1 : lvl;
        d = BASE_DIV - 2 * (l - 1);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    task automatic model_step();
        bit rise;
        if (rst) begin
            m_phase = 0; m_lives = 0; m_level = 0; m_score = 0; m_rem = 0; m_pause = 0;
            m_prev  = 1'b1;
            m_valid = 1'b1;
            return;
        end
        rise   = game_active && !m_prev;
        m_prev = game_active;
        if (!game_active) begin
            m_phase = 0;
            return;
        end
        case (m_phase)
            0: if (rise) begin
                m_lives = LIVES_INIT; m_level = 1; m_score = 0; m_rem = INVADER_COUNT;
                m_pause = (BREAK_FRAMES < 1) ? 1 : BREAK_FRAMES;
                m_phase = 1;
            end
            1, 3: if (frame_tick) begin
                if (m_pause == 1) m_phase = 2;
                m_pause--;
            end
            2: begin
                if (invader_killed) begin
                    m_score = (m_score + POINTS > 65535) ? 65535 : m_score + POINTS;
                    if (m_rem > 0) m_rem--;
                end
                if (invaders_landed) begin
                    m_lives = 0;
                    m_phase = 4;
                end else if (player_hit) begin
                    m_lives--;
                    if (m_lives == 0) m_phase = 4;
                    else begin
                        m_phase = 3;
                        m_pause = HIT_FRAMES;
                    end
                end else if (m_rem == 0) begin
                    m_level = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
                    m_rem   = INVADER_COUNT;
                    m_pause = BREAK_FRAMES;
                    m_phase = 1;
                end
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("cyc.phase",      int'(phase),      m_phase);
            chk("cyc.player_en",  int'(player_en),  int'(m_phase == 2));
            chk("cyc.invader_en", int'(invader_en), int'(m_phase == 2));
            chk("cyc.lives",      int'(lives),      m_lives);
            chk("cyc.level",      int'(level),      m_level);
            chk("cyc.score",      int'(score),      m_score);
            chk("cyc.game_over",  int'(game_over),  int'(m_phase == 4));
            chk("cyc.step_div",   int'(step_div),   exp_step_div(m_level));
        end
    end

    task automatic expect_state(input string tag, input int e_phase, input int e_lives,
                                input int e_level, input int e_score);
        chk({tag, ".phase"}, int'(phase), e_phase);
        chk({tag, ".lives"}, int'(lives), e_lives);
        chk({tag, ".level"}, int'(level), e_level);
        chk({tag, ".score"}, int'(score), e_score);
    endtask

    task automatic pulse(input bit ft, input bit hit, input bit kill, input bit land);
        frame_tick = ft; player_hit = hit; invader_killed = kill; invaders_landed = land;
        @(negedge clk);
        frame_tick = 1'b0; player_hit = 1'b0; invader_killed = 1'b0; invaders_landed = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            gap(1);
        end
    endtask

    task automatic fast_ticks(input int n);
        repeat (n) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic restart_round();
        game_active = 1'b0; gap(1);
        game_active = 1'b1; gap(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; game_active = 1'b0; frame_tick = 1'b0;
        player_hit = 1'b0; invader_killed = 1'b0; invaders_landed = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_state("reset", 0, 0, 0, 0);
        chk("reset.step_div", int'(step_div), 16);
        chk("reset.player_en", int'(player_en), 0);
        chk("reset.game_over", int'(game_over), 0);
        gap(1);

        // Round 1: start banner, full wave, three hits to OVER.
        game_active = 1'b1; gap(1);
        chk("start.phase", int'(phase), 1);
        ticks(89);
        chk("banner89.phase", int'(phase), 1);
        ticks(1);
        expect_state("play1", 2, 3, 1, 0);
        chk("play1.step_div", int'(step_div), 16);
        chk("play1.player_en", int'(player_en), 1);
        repeat (31) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_state("kills31", 2, 3, 1, 310);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_state("wave1", 1, 3, 2, 320);
        chk("wave1.step_div", int'(step_div), 14);
        chk("wave1.invader_en", int'(invader_en), 0);
        ticks(90);
        chk("wave2.phase", int'(phase), 2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_state("hit1", 3, 2, 2, 320);
        ticks(59);
        chk("hit1_59.phase", int'(phase), 3);
        ticks(1);
        chk("hit1_done.phase", int'(phase), 2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_state("hit2", 3, 1, 2, 320);
        ticks(60);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_state("hit3", 4, 0, 2, 320);
        chk("hit3.game_over", int'(game_over), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("over_pulses", 4, 0, 2, 320);
        game_active = 1'b0; gap(1);
        expect_state("drop", 0, 0, 2, 320);
        chk("drop.game_over", int'(game_over), 0);

        // Round 2: hit and last kill in the same cycle, deferred wave clear.
        game_active = 1'b1; gap(1);
        expect_state("r2", 1, 3, 1, 0);
        ticks(90);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_state("r2hit", 3, 2, 1, 0);
        ticks(60);
        repeat (31) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_state("r2kills", 2, 2, 1, 310);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        expect_state("hit_kill", 3, 1, 1, 320);
        ticks(59);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_state("reentry", 2, 1, 1, 320);
        gap(1);
        expect_state("deferred_clear", 1, 1, 2, 320);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("break_pulses", 1, 1, 2, 320);

        // Round 3: invaders landing with full lives.
        restart_round();
        ticks(90);
        expect_state("r3", 2, 3, 1, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("landed", 4, 0, 1, 0);
        chk("landed.game_over", int'(game_over), 1);

        // Round 4: many waves to saturate level and score.
        restart_round();
        ticks(90);
        for (int w = 1; w <= 205; w++) begin
            repeat (32) pulse(1'b0, 1'b0, 1'b1, 1'b0);
            fast_ticks(90);
            if (w == 13) chk("w13.level", int'(level), 14);
            if (w == 14) chk("w14.level", int'(level), 15);
            if (w == 15) begin
                chk("w15.level", int'(level), 15);
                chk("w15.step_div", int'(step_div), 4);
            end
            if (w == 204) chk("w204.score", int'(score), 65280);
        end
        expect_state("saturated", 2, 3, 15, 65535);
        chk("saturated.step_div", int'(step_div), 4);

        // Reset in the middle of a HIT pause; game_active stays high.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_state("pre_rst_hit", 3, 2, 15, 65535);
        ticks(10);
        rst = 1'b1; gap(1);
        rst = 1'b0;
        expect_state("mid_rst", 0, 0, 0, 0);
        chk("mid_rst.step_div", int'(step_div), 16);
        gap(5);
        chk("no_restart.phase", int'(phase), 0);
        restart_round();
        expect_state("after_toggle", 1, 3, 1, 0);
        game_active = 1'b0; gap(1);
        chk("fall.phase", int'(phase), 0);
        game_active = 1'b1; gap(1);
        chk("blip_rise.phase", int'(phase), 1);
        game_active = 1'b0; gap(1);
        chk("blip_fall.phase", int'(phase), 0);
        gap(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_controller.md
# game_round_controller

Sequences a round of play while the top-level game state is GAME. Tracks lives, wave level, remaining invaders and score, and inserts timed pauses after a player hit and between waves. Gates the player and invader datapaths through enable outputs. Raises `game_over` back to the top-level menu/game/end state machine.

## Interface

- `LIVES_INIT`, 3: lives at round start (1–3).
- `INVADER_COUNT`, 32: invaders per wave (1–63).
- `HIT_FRAMES`, 60: frames frozen after a player hit.
- `BREAK_FRAMES`, 90: frames of inter-wave/start banner.
- `MAX_LEVEL`, 15: level saturates here.
- `POINTS`, 10: score per kill.
- `BASE_DIV`, 16 / `MIN_DIV`, 4: invader step divisor at level 1 / floor.

- `clk` in 1: system clock; one clock, reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `game_active` in 1: high while the top-level state is GAME.
- `player_hit` in 1: one-cycle pulse, player destroyed.
- `invader_killed` in 1: one-cycle pulse, one invader destroyed.
- `invaders_landed` in 1: level, an invader reached the player row.
- `phase` out 3: current state encoding (below).
- `player_en` out 1: player movement/fire allowed.
- `invader_en` out 1: invader march/fire allowed.
- `step_div` out 5: frames per invader step.
- `lives` out 2: remaining lives.
- `level` out 4: current wave, 1-based.
- `score` out 16: saturating score.
- `game_over` out 1: level, high in OVER.

## Operation

- States: IDLE=0, BREAK=1, PLAY=2, HIT=3, OVER=4.
- IDLE:
  - all enables 0.
  - On a `game_active` rising edge (registered previous value, edge detected at clk), load lives=LIVES_INIT, level=1, score=0, remaining=INVADER_COUNT, pause_cnt=BREAK_FRAMES, then go to BREAK.
- BREAK:
  - enables 0.
  - pause_cnt decrements on `frame_tick`.
  - A `frame_tick` seen while pause_cnt==1 goes to PLAY.
  - BREAK_FRAMES=0 is treated as 1.
- PLAY:
  - `player_en`=`invader_en`=1.
  - Priority, evaluated on the same cycle: (1) `invaders_landed` goes to OVER, lives forced to 0; (2) `player_hit` decrements lives, then goes to OVER if the result is 0, else to HIT with pause_cnt=HIT_FRAMES; (3) remaining reaching 0 after a kill increments level (saturating at MAX_LEVEL), reloads remaining=INVADER_COUNT, sets pause_cnt=BREAK_FRAMES and goes to BREAK.
  - `invader_killed` always adds POINTS to score (saturating at 0xFFFF) and decrements remaining (never below 0), even when a hit wins the same cycle.
  - A remaining count that reaches 0 under a winning hit is resolved on PLAY re-entry, one cycle after entry.
- HIT:
  - enables 0.
  - Counts down like BREAK, then returns to PLAY.
  - remaining is retained.
- OVER:
  - `game_over`=1, enables 0.
  - Held until `game_active` falls.
- From any state, `game_active` low goes to IDLE next cycle. Lives, level and score are held for display.
- Event pulses outside PLAY are ignored.
- `step_div` = max(BASE_DIV − 2·(level−1), MIN_DIV). It is combinational from registered `level`, width 5, computed without underflow.

## Timing

- All outputs are registered except `step_div`. State changes take effect the clk after the triggering input.
- Reset values: phase=IDLE, player_en=0, invader_en=0, lives=0, level=0, score=0, game_over=0, step_div=BASE_DIV.
- Reset mid-round: returns to IDLE next cycle with all counters cleared. An already-high `game_active` does not restart the round until it toggles.
- Frame counting uses `frame_tick` only; a pause lasts exactly N ticks.
- `game_active` rise and fall in consecutive cycles: IDLE→BREAK→IDLE.

## Structure

- Shared package `chip_invaders_pkg`: `round_phase_t` enum (IDLE…OVER); score and level widths.
- The existing top-level state encoding constants (MENU/GAME/END) also move into this package.
- Natural sub-module: `frame_countdown`. It loads N, decrements on `frame_tick` and pulses `done`, and serves both HIT and BREAK.

## Test plan

- Reset, then `game_active` rise → BREAK. After 90 `frame_tick`s → PLAY with lives=3, level=1, score=0, step_div=16.
- 32 `invader_killed` pulses in PLAY → score=320, level=2, phase=BREAK, step_div=14, enables 0 the cycle after the 32nd kill.
- `player_hit` three times, each HIT lasting 60 ticks → lives 2,1 then OVER with game_over=1. Drop `game_active` → IDLE, lives=0 held.
- Same cycle: `player_hit` plus the last `invader_killed` with lives=2 → lives=1, HIT, score +10, level unchanged. After 60 ticks: PLAY, then BREAK one cycle later with level+1.
- `invaders_landed` with lives=3 → OVER next cycle, lives=0. Pulses in OVER and BREAK leave score and lives unchanged.
- Score preloaded near 0xFFFF via kills → saturates at 0xFFFF. Level forced to 15 plus a cleared wave → stays 15, step_div=4. Assert `rst` mid-HIT → IDLE next cycle.
